record_playback_ctrl: RTL and testbench
=======================================

# record_playback_ctrl

Sequencer for the 64K x 16 sample store: records a stream of 16-bit audio samples into the memory and plays them back at a tick rate. It sits between the ADC sample path, the user command inputs and the `memory_storage` instance, and is the only driver of the memory's write, address and data-in pins. It tracks the recorded length, and optionally loops playback.

## Interface
- `ADDR_W`, 16: memory address width; capacity `DEPTH = 2**ADDR_W` samples.
- `clk` in 1: single system clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `rec_start` in 1: single-cycle pulse; begin recording from address 0.
- `play_start` in 1: single-cycle pulse; begin playback from address 0.
- `stop` in 1: single-cycle pulse; end the current record or playback.
- `loop` in 1: level; when 1, playback wraps to address 0 instead of ending.
- `sample_valid` in 1: single-cycle strobe; `sample_in` is a new sample.
- `sample_in` in 16: sample to record.
- `play_tick` in 1: single-cycle strobe; emit the next playback sample.
- `mem_dataout` in 16: memory read data, valid the cycle after the address is presented.
- `mem_write` out 1: memory write enable (registered).
- `mem_address` out ADDR_W: memory address (registered).
- `mem_datain` out 16: memory write data (registered).
- `sample_out` out 16: playback sample (registered).
- `sample_out_valid` out 1: one-cycle strobe qualifying `sample_out`.
- `recording` out 1: state is RECORD.
- `playing` out 1: state is PLAY.
- `full` out 1: the last recording filled all `DEPTH` locations.
- `rec_length` out ADDR_W+1: number of samples in the last recording (0..DEPTH).

## Operation
- States: IDLE, RECORD, PLAY. `recording` and `playing` decode the state directly.
- Reset (synchronous) forces these values: state IDLE; `mem_write`=0; `mem_address`=0; `mem_datain`=0; `sample_out`=0; `sample_out_valid`=0; `full`=0; `rec_length`=0; pointers 0; read pipeline flags cleared.
- Command priority in any state:
  - `stop` beats `rec_start`, which beats `play_start`.
  - A start while already in RECORD or PLAY restarts that mode from address 0.
- IDLE -> RECORD on `rec_start`:
  - Clears the write pointer, `rec_length` and `full`.
- RECORD behaviour:
  - Each `sample_valid` writes `sample_in` at the write pointer, then increments the pointer and `rec_length`.
  - When the write at address DEPTH-1 is issued, the block sets `full`=1 and `rec_length`=DEPTH, then returns to IDLE. Further `sample_valid` strobes are ignored.
  - `stop` returns to IDLE and keeps `rec_length`. A `sample_valid` in the same cycle as `stop` is dropped.
- IDLE -> PLAY on `play_start`, only if `rec_length` != 0. Otherwise `play_start` is ignored and the state stays IDLE.
- PLAY behaviour:
  - Each `play_tick` issues a read at the read pointer, then increments the pointer.
  - After the read at address `rec_length`-1:
    - `loop`=0: go to IDLE.
    - `loop`=1: the read pointer wraps to 0 and the state stays PLAY.
  - `stop` returns to IDLE. A `stop` does not cancel a read already issued; its `sample_out_valid` still fires.
- `mem_write` is 0 in every cycle that is not a write. `sample_valid` in IDLE or PLAY, and `play_tick` outside PLAY, are ignored.
- Arithmetic: the pointers are ADDR_W-bit and wrap naturally. `rec_length` is ADDR_W+1 bits so that DEPTH can be represented.

## Timing
- Write:
  - `sample_valid` sampled at edge E -> `mem_write`=1, `mem_address`=ptr and `mem_datain`=sample during the next cycle (exactly one cycle).
  - The memory latches the write at edge E+1.
- Read (total latency 3 cycles):
  - `play_tick` sampled at edge E -> `mem_address` valid in cycle E+1, with `mem_write`=0.
  - `mem_dataout` is valid in cycle E+2.
  - It is registered at edge E+3, so `sample_out` and `sample_out_valid` are seen in the cycle after edge E+3.
- Back-to-back strobes are legal. One write or read may issue per cycle; the read pipeline is fully pipelined.
- Reset asserted mid-operation takes effect at the next edge and drops any in-flight `sample_out_valid`.

## Test plan
- Reset, then idle: all outputs 0. `play_start` with `rec_length`=0 -> remains IDLE, no `mem_write`, no `sample_out_valid`.
- `rec_start`, then 4 `sample_valid` with 0x1111..0x4444, then `stop`:
  - `mem_write` pulses at addresses 0..3 with matching data.
  - `rec_length`=4, `full`=0, IDLE.
- `play_start`, `loop`=0, 5 `play_tick` against a memory model:
  - `sample_out` = 0x1111..0x4444, each 3 cycles after its tick.
  - The 5th tick is ignored; `playing` drops after the 4th read issues.
- `loop`=1, 6 ticks on `rec_length`=4 -> output sequence 0x1111, 0x2222, 0x3333, 0x4444, 0x1111, 0x2222.
- Record 65536 samples with consecutive `sample_valid`:
  - The last write is at 0xFFFF, then `full`=1, `rec_length`=65536, IDLE.
  - A 65537th strobe produces no write.
- Same-cycle `stop` + `sample_valid` in RECORD -> no write. Same-cycle `rec_start` + `play_start` in IDLE -> RECORD. `reset` during PLAY with a tick in flight -> no `sample_out_valid`, all outputs at reset values.

Source files
------------

// File: rtl/record_playback_ctrl.sv
// Record/playback sequencer for a 2**ADDR_W x 16 sample memory.
// Sole driver of the memory write/address/data pins; read data is registered through a 3-stage pipe.
module record_playback_ctrl #(
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rec_start,
  input  logic              play_start,
  input  logic              stop,
  input  logic              loop,
  input  logic              sample_valid,
  input  logic [15:0]       sample_in,
  input  logic              play_tick,
  input  logic [15:0]       mem_dataout,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [15:0]       mem_datain,
  output logic [15:0]       sample_out,
  output logic              sample_out_valid,
  output logic              recording,
  output logic              playing,
  output logic              full,
  output logic [ADDR_W:0]   rec_length
);

  typedef enum logic [1:0] {StIdle, StRecord, StPlay} state_e;

  localparam logic [ADDR_W-1:0] PtrOne = 1;
  localparam logic [ADDR_W:0]   LenOne = 1;

  state_e              state_q;
  logic [ADDR_W-1:0]   wr_ptr_q;
  logic [ADDR_W-1:0]   rd_ptr_q;
  logic                rd_v1_q;
  logic                rd_v2_q;
  logic                rd_v3_q;
  logic [15:0]         rd_data_q;
  logic                last_rd;

  assign last_rd   = ({1'b0, rd_ptr_q} == (rec_length - LenOne));
  assign recording = (state_q == StRecord);
  assign playing   = (state_q == StPlay);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= StIdle;
      mem_write        <= 1'b0;
      mem_address      <= '0;
      mem_datain       <= '0;
      sample_out       <= '0;
      sample_out_valid <= 1'b0;
      full             <= 1'b0;
      rec_length       <= '0;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      rd_v1_q          <= 1'b0;
      rd_v2_q          <= 1'b0;
      rd_v3_q          <= 1'b0;
      rd_data_q        <= '0;
    end else begin
      mem_write <= 1'b0;
      // Read pipe: address out, memory latency, capture, output register.
      rd_v1_q          <= 1'b0;
      rd_v2_q          <= rd_v1_q;
      rd_v3_q          <= rd_v2_q;
      sample_out_valid <= rd_v3_q;
      if (rd_v2_q) rd_data_q  <= mem_dataout;
      if (rd_v3_q) sample_out <= rd_data_q;

      if (stop) begin
        state_q <= StIdle;
      end else if (rec_start) begin
        state_q    <= StRecord;
        wr_ptr_q   <= '0;
        rec_length <= '0;
        full       <= 1'b0;
      end else if (play_start && (rec_length != '0)) begin
        state_q  <= StPlay;
        rd_ptr_q <= '0;
      end else begin
        case (state_q)
          StRecord: begin
            if (sample_valid) begin
              mem_write   <= 1'b1;
              mem_address <= wr_ptr_q;
              mem_datain  <= sample_in;
              wr_ptr_q    <= wr_ptr_q + PtrOne;
              rec_length  <= rec_length + LenOne;
              if (wr_ptr_q == '1) begin
                full    <= 1'b1;
                state_q <= StIdle;
              end
            end
          end
          StPlay: begin
            if (play_tick) begin
              mem_address <= rd_ptr_q;
              rd_v1_q     <= 1'b1;
              if (last_rd) begin
                rd_ptr_q <= '0;
                if (!loop) state_q <= StIdle;
              end else begin
                rd_ptr_q <= rd_ptr_q + PtrOne;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_record_playback_ctrl.sv
// Directed bench for record_playback_ctrl with a behavioural 64K x 16 memory model.
module tb_record_playback_ctrl;

  logic        clk = 1'b0;
  logic        reset, rec_start, play_start, stop, loop, sample_valid, play_tick;
  logic [15:0] sample_in, mem_dataout;
  logic        mem_write, sample_out_valid, recording, playing, full;
  logic [15:0] mem_address, mem_datain, sample_out;
  logic [16:0] rec_length;

  logic [15:0] mem [0:65535];

  int          n_checks = 0;
  int          n_pass = 0;
  int          cyc = 0;
  logic [15:0] wr_addr_q[$];
  logic [15:0] wr_data_q[$];
  logic [15:0] out_q[$];
  int          out_cyc_q[$];
  int          tick_cyc[6];

  always #5 clk = ~clk;

  record_playback_ctrl #(.ADDR_W(16)) dut (
    .clk              (clk),
    .reset            (reset),
    .rec_start        (rec_start),
    .play_start       (play_start),
    .stop             (stop),
    .loop             (loop),
    .sample_valid     (sample_valid),
    .sample_in        (sample_in),
    .play_tick        (play_tick),
    .mem_dataout      (mem_dataout),
    .mem_write        (mem_write),
    .mem_address      (mem_address),
    .mem_datain       (mem_datain),
    .sample_out       (sample_out),
    .sample_out_valid (sample_out_valid),
    .recording        (recording),
    .playing          (playing),
    .full             (full),
    .rec_length       (rec_length)
  );

  // Synchronous memory: one-cycle read latency.
  always @(posedge clk) begin
    if (mem_write) mem[mem_address] <= mem_datain;
    mem_dataout <= mem[mem_address];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Advance one edge, then sample and log outputs.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (mem_write) begin
      wr_addr_q.push_back(mem_address);
      wr_data_q.push_back(mem_datain);
    end
    if (sample_out_valid) begin
      out_q.push_back(sample_out);
      out_cyc_q.push_back(cyc);
    end
  endtask

  task automatic clear_logs();
    wr_addr_q.delete();
    wr_data_q.delete();
    out_q.delete();
    out_cyc_q.delete();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int errs;
    reset = 1'b1; rec_start = 0; play_start = 0; stop = 0; loop = 0;
    sample_valid = 0; play_tick = 0; sample_in = '0;
    steps(2);
    reset = 1'b0;
    step();
    check("rst_mem_write", mem_write, 0);
    check("rst_mem_address", mem_address, 0);
    check("rst_mem_datain", mem_datain, 0);
    check("rst_sample_out", sample_out, 0);
    check("rst_out_valid", sample_out_valid, 0);
    check("rst_recording", recording, 0);
    check("rst_playing", playing, 0);
    check("rst_full", full, 0);
    check("rst_rec_length", rec_length, 0);

    // play_start with nothing recorded is ignored
    play_start = 1; step(); play_start = 0;
    check("empty_play_state", playing, 0);
    play_tick = 1; steps(2); play_tick = 0;
    steps(4);
    check("empty_play_writes", wr_addr_q.size(), 0);
    check("empty_play_outs", out_q.size(), 0);

    // Record four samples back to back
    clear_logs();
    rec_start = 1; step(); rec_start = 0;
    check("rec_state", recording, 1);
    for (int i = 0; i < 4; i++) begin
      sample_valid = 1; sample_in = 16'(16'h1111 * (i + 1)); step();
    end
    sample_valid = 0; stop = 1; step(); stop = 0; step();
    check("rec4_nwrites", wr_addr_q.size(), 4);
    for (int i = 0; i < 4 && i < wr_addr_q.size(); i++) begin
      check("rec4_addr", wr_addr_q[i], i);
      check("rec4_data", wr_data_q[i], 16'h1111 * (i + 1));
    end
    check("rec4_length", rec_length, 4);
    check("rec4_full", full, 0);
    check("rec4_idle", recording, 0);

    // Playback without loop: fifth tick ignored
    clear_logs();
    loop = 0; play_start = 1; step(); play_start = 0;
    check("play_state", playing, 1);
    for (int k = 0; k < 5; k++) begin
      play_tick = 1; step();
      tick_cyc[k] = cyc;
      if (k == 3) check("play_drop_after_4th", playing, 0);
    end
    play_tick = 0;
    steps(6);
    check("play_nouts", out_q.size(), 4);
    for (int k = 0; k < 4 && k < out_q.size(); k++) begin
      check("play_data", out_q[k], 16'h1111 * (k + 1));
      check("play_latency", out_cyc_q[k] - tick_cyc[k], 3);
    end
    check("play_no_write", wr_addr_q.size(), 0);

    // Looped playback wraps after rec_length samples
    clear_logs();
    loop = 1; play_start = 1; step(); play_start = 0;
    play_tick = 1; steps(6); play_tick = 0;
    check("loop_still_playing", playing, 1);
    stop = 1; step(); stop = 0;
    steps(5);
    check("loop_stopped", playing, 0);
    check("loop_nouts", out_q.size(), 6);
    for (int k = 0; k < 6 && k < out_q.size(); k++)
      check("loop_data", out_q[k], 16'h1111 * ((k % 4) + 1));
    loop = 0;

    // stop + sample_valid in the same cycle drops the sample
    clear_logs();
    rec_start = 1; step(); rec_start = 0;
    sample_valid = 1; stop = 1; sample_in = 16'hDEAD; step();
    sample_valid = 0; stop = 0; steps(2);
    check("stop_sv_nwrites", wr_addr_q.size(), 0);
    check("stop_sv_idle", recording, 0);
    check("stop_sv_length", rec_length, 0);

    // rec_start beats play_start
    rec_start = 1; play_start = 1; step(); rec_start = 0; play_start = 0;
    check("prio_recording", recording, 1);
    check("prio_playing", playing, 0);
    sample_valid = 1; sample_in = 16'hAAAA; step();
    sample_in = 16'hBBBB; step();
    sample_valid = 0; stop = 1; step(); stop = 0;
    check("rec2_length", rec_length, 2);

    // Reset with a read in flight
    clear_logs();
    play_start = 1; step(); play_start = 0;
    play_tick = 1; step(); play_tick = 0;
    step();
    reset = 1; step(); reset = 0;
    steps(4);
    check("rstplay_outs", out_q.size(), 0);
    check("rstplay_playing", playing, 0);
    check("rstplay_sample_out", sample_out, 0);
    check("rstplay_address", mem_address, 0);
    check("rstplay_length", rec_length, 0);

    // Fill the whole memory, then one extra strobe
    clear_logs();
    rec_start = 1; step(); rec_start = 0;
    for (int i = 0; i < 65536; i++) begin
      sample_valid = 1; sample_in = 16'(i) ^ 16'h5A5A; step();
    end
    check("full_flag", full, 1);
    check("full_length", rec_length, 17'd65536);
    check("full_idle", recording, 0);
    sample_in = 16'h1234; step();
    sample_valid = 0; step();
    check("full_nwrites", wr_addr_q.size(), 65536);
    errs = 0;
    for (int i = 0; i < wr_addr_q.size(); i++)
      if (wr_addr_q[i] !== 16'(i) || wr_data_q[i] !== (16'(i) ^ 16'h5A5A)) errs++;
    check("full_seq_errs", errs, 0);
    if (wr_addr_q.size() > 0) check("full_last_addr", wr_addr_q[wr_addr_q.size() - 1], 16'hFFFF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
